fetch_stage: RTL

//  Instruction fetch front end of the RISC-V core. It drives the fetch-to-decode latch (DE_NPC, DE_IR,
//  DE_V) that decode consumes, and it honours decode's stall. It issues one outstanding request at a

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: one outstanding imem request, a skid buffer for decode stalls,
// and branch redirect with flush. The FSM state is exported on state_dbg.
module fetch_stage #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned INSN_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        de_stall,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   output logic [63:0] de_npc,
   output logic [31:0] de_ir,
   output logic        de_v,
   output logic [2:0]  state_dbg
);

   // Handshake: a request is accepted on any rising edge where imem_req && imem_ready;
   // exactly one imem_rvalid follows each accept, at the earliest one cycle later.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_DROP = 3'd4
   } state_t;

   localparam logic [63:0] STEP = 64'(INSN_BYTES);

   state_t      state, state_n;
   logic [63:0] pc, pc_n;
   logic [63:0] infl, infl_n;
   logic [31:0] buf_ir, buf_ir_n;
   logic [63:0] buf_pc, buf_pc_n;
   logic [63:0] de_npc_n;
   logic [31:0] de_ir_n;
   logic        de_v_n;
   logic        accept;
   logic        de_free;

   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;
   assign state_dbg = state;
   assign accept    = imem_req && imem_ready;
   assign de_free   = !de_v || !de_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pc     <= RESET_PC;
         infl   <= 64'h0;
         buf_ir <= 32'h0;
         buf_pc <= 64'h0;
         de_npc <= 64'h0;
         de_ir  <= 32'h0;
         de_v   <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         infl   <= infl_n;
         buf_ir <= buf_ir_n;
         buf_pc <= buf_pc_n;
         de_npc <= de_npc_n;
         de_ir  <= de_ir_n;
         de_v   <= de_v_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      infl_n   = infl;
      buf_ir_n = buf_ir;
      buf_pc_n = buf_pc;
      de_npc_n = de_npc;
      de_ir_n  = de_ir;
      de_v_n   = de_v;

      if (br_taken) begin
         // Redirect wins over everything, including a stalled decode latch.
         pc_n     = br_target & ~64'h3;
         de_v_n   = 1'b0;
         de_ir_n  = 32'h0;
         buf_ir_n = 32'h0;
         buf_pc_n = 64'h0;
         unique case (state)
            S_REQ:   state_n = accept ? S_DROP : S_REQ;
            S_WAIT:  state_n = imem_rvalid ? S_REQ : S_DROP;
            S_DROP:  state_n = S_DROP;
            default: state_n = S_REQ;
         endcase
      end else begin
         if (de_v && !de_stall) begin
            de_v_n = 1'b0;
         end
         unique case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
               if (accept) begin
                  infl_n  = pc;
                  state_n = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (de_free) begin
                     de_ir_n  = imem_rdata;
                     de_npc_n = infl;
                     de_v_n   = 1'b1;
                     pc_n     = infl + STEP;
                     state_n  = S_REQ;
                  end else begin
                     buf_ir_n = imem_rdata;
                     buf_pc_n = infl;
                     state_n  = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!de_stall) begin
                  de_ir_n  = buf_ir;
                  de_npc_n = buf_pc;
                  de_v_n   = 1'b1;
                  pc_n     = buf_pc + STEP;
                  state_n  = S_REQ;
               end
            end
            S_DROP: begin
               // The response to the abandoned request is swallowed here.
               if (imem_rvalid) begin
                  state_n = S_REQ;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule
